// File: rtl/dmg_timer_pkg.sv
// Shared constants and types for the DMG timer/divider block.
package dmg_timer_pkg;

    // Register map on the 2-bit CPU address bus.
    localparam logic [1:0] ADDR_DIV  = 2'd0;
    localparam logic [1:0] ADDR_TIMA = 2'd1;
    localparam logic [1:0] ADDR_TMA  = 2'd2;
    localparam logic [1:0] ADDR_TAC  = 2'd3;

    // TAC fields: bit 2 enables the timer, bits 1:0 pick the divider tap.
    localparam int         TAC_W      = 3;
    localparam int         TAC_EN_BIT = 2;
    localparam logic [4:0] TAC_RD_PAD = 5'b11111;

    // TIMA sequencing: normal counting, overflow wait, one-clk reload.
    typedef enum logic [1:0] {
        COUNT,
        OVF,
        RELOAD
    } state_t;

endpackage

// File: rtl/dmg_fall_edge.sv
// Registered falling-edge detector: one-clk pulse when sig goes 1 -> 0.
module dmg_fall_edge (
    input  logic clk,
    input  logic nreset,
    input  logic sig,
    output logic fall
);

    logic prev;

    // Remember last clk's value of sig.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!nreset) prev <= 1'b0;
        else         prev <= sig;
    end

    assign fall = prev & ~sig;

endmodule

// File: rtl/dmg_timer_div.sv
// DMG divider + TIMA timer: free-running divider, tap-selected TIMA clock,
// delayed TMA reload on overflow and a one-clk timer interrupt.
module dmg_timer_div
    import dmg_timer_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int TIMA_W       = 8,
    parameter int TAP0         = 9,
    parameter int TAP1         = 3,
    parameter int TAP2         = 5,
    parameter int TAP3         = 7,
    parameter int RELOAD_DELAY = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             ce,
    input  logic             cpu_wr,
    input  logic [1:0]       addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic             irq_timer,
    output logic [DIV_W-1:0] div_taps
);

    localparam int RLD_W = $clog2(RELOAD_DELAY + 1);

    logic [DIV_W-1:0]  div;
    logic [TIMA_W-1:0] tima, tima_nxt;
    logic [TIMA_W-1:0] tma;
    logic [TAC_W-1:0]  tac;
    logic [RLD_W-1:0]  rld_cnt, rld_nxt;
    state_t            state, state_nxt;
    logic              tap_bit, sel, inc_req;

    wire div_wr  = cpu_wr && (addr == ADDR_DIV);
    wire tima_wr = cpu_wr && (addr == ADDR_TIMA);
    wire tma_wr  = cpu_wr && (addr == ADDR_TMA);
    wire tac_wr  = cpu_wr && (addr == ADDR_TAC);

    // Free-running divider; a DIV write clears it and beats ce.
    always_ff @(posedge clk) begin
        if (!nreset)     div <= '0;
        else if (div_wr) div <= '0;
        else if (ce)     div <= div + 1'b1;
    end

    // Tap mux feeding the TIMA clock; gated by the TAC enable bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        tap_bit = 1'b0;
        case (tac[1:0])
            2'd0: tap_bit = div[TAP0];
            2'd1: tap_bit = div[TAP1];
            2'd2: tap_bit = div[TAP2];
            2'd3: tap_bit = div[TAP3];
            default: tap_bit = 1'b0;
        endcase
        sel = tac[TAC_EN_BIT] & tap_bit;
    end

    // Any 1 -> 0 on sel counts, including the DIV-clear and TAC-write glitches.
    dmg_fall_edge u_fall (
        .clk    (clk),
        .nreset (nreset),
        .sig    (sel),
        .fall   (inc_req)
    );

    // Plain register writes for TMA and TAC.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            tma <= '0;
            tac <= '0;
        end else begin
            if (tma_wr) tma <= wdata[TIMA_W-1:0];
            if (tac_wr) tac <= wdata[TAC_W-1:0];
        end
    end

    // TIMA state, counter and reload countdown registers.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state   <= COUNT;
            tima    <= '0;
            rld_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tima    <= tima_nxt;
            rld_cnt <= rld_nxt;
        end
    end

    // TIMA next-state: count, overflow wait, reload.
    always_comb begin
        state_nxt = state;
        tima_nxt  = tima;
        rld_nxt   = rld_cnt;
        case (state)
            COUNT: begin
                if (tima_wr) begin
                    tima_nxt = wdata[TIMA_W-1:0];
                end else if (inc_req) begin
                    if (&tima) begin
                        tima_nxt  = '0;
                        rld_nxt   = RLD_W'(RELOAD_DELAY);
                        state_nxt = OVF;
                    end else begin
                        tima_nxt = tima + 1'b1;
                    end
                end
            end
            OVF: begin
                // Increment requests are dropped while waiting for the reload.
                if (tima_wr) begin
                    tima_nxt  = wdata[TIMA_W-1:0];
                    rld_nxt   = '0;
                    state_nxt = COUNT;
                end else if (ce) begin
                    rld_nxt = rld_cnt - 1'b1;
                    if (rld_cnt == RLD_W'(1)) state_nxt = RELOAD;
                end
            end
            RELOAD: begin
                // A TMA write in this clk feeds straight through; TIMA writes lose.
                tima_nxt  = tma_wr ? wdata[TIMA_W-1:0] : tma;
                state_nxt = COUNT;
            end
            default: state_nxt = COUNT;
        endcase
    end

    assign irq_timer = (state == RELOAD);
    assign div_taps  = div;

    // Combinational register read-back.
    always_comb begin
        rdata = 8'h00;
        case (addr)
            ADDR_DIV:  rdata = div[DIV_W-1 -: 8];
            ADDR_TIMA: rdata = 8'(tima);
            ADDR_TMA:  rdata = 8'(tma);
            ADDR_TAC:  rdata = {TAC_RD_PAD, tac};
            default:   rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_dmg_timer_div.sv
// Bench for dmg_timer_div: two configurations driven in parallel, each
// checked every clk against a behavioural model, plus literal spot checks.
module tb_dmg_timer_div;

    logic        clk = 1'b0;
    logic        nreset, ce, cpu_wr;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata_a, rdata_b;
    logic        irq_a, irq_b;
    logic [15:0] taps_a;
    logic [11:0] taps_b;

    int vectors = 0;
    int miscompares = 0;
    bit started = 0;

    always #5 clk = ~clk;

    dmg_timer_div u_dut_a (
        .clk(clk), .nreset(nreset), .ce(ce), .cpu_wr(cpu_wr), .addr(addr),
        .wdata(wdata), .rdata(rdata_a), .irq_timer(irq_a), .div_taps(taps_a)
    );

    dmg_timer_div #(.DIV_W(12), .TIMA_W(4), .RELOAD_DELAY(1)) u_dut_b (
        .clk(clk), .nreset(nreset), .ce(ce), .cpu_wr(cpu_wr), .addr(addr),
        .wdata(wdata), .rdata(rdata_b), .irq_timer(irq_b), .div_taps(taps_b)
    );

    // ---------------- behavioural model ----------------
    // Overflow handling is a countdown: -1 counting, >0 ce-ticks left, 0 = reload clk.
    int dw[2]   = '{16, 12};
    int tw[2]   = '{8, 4};
    int rdl[2]  = '{4, 1};
    int tap[4]  = '{9, 3, 5, 7};
    int m_div[2], m_tima[2], m_tma[2], m_tac[2], m_left[2];
    bit m_prev[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_rdata(input int k, input logic [1:0] a);
        case (a)
            2'd0:    return 8'((m_div[k] >> (dw[k] - 8)) & 8'hFF);
            2'd1:    return 8'(m_tima[k]);
            2'd2:    return 8'(m_tma[k]);
            default: return 8'(8'hF8 | m_tac[k]);
        endcase
    endfunction

    always @(posedge clk) begin
        int dmask, tmask, n_tima, n_left;
        bit sel, fall, w_div, w_tima, w_tma, w_tac;
        w_div  = cpu_wr && addr == 2'd0;
        w_tima = cpu_wr && addr == 2'd1;
        w_tma  = cpu_wr && addr == 2'd2;
        w_tac  = cpu_wr && addr == 2'd3;
        for (int k = 0; k < 2; k++) begin
            if (!nreset) begin
                m_div[k] = 0; m_tima[k] = 0; m_tma[k] = 0; m_tac[k] = 0;
                m_left[k] = -1; m_prev[k] = 0;
            end else begin
                dmask = (1 << dw[k]) - 1;
                tmask = (1 << tw[k]) - 1;
                sel  = m_tac[k][2] && m_div[k][tap[m_tac[k][1:0]]];
                fall = m_prev[k] && !sel;
                n_tima = m_tima[k];
                n_left = m_left[k];
                if (m_left[k] < 0) begin
                    if (w_tima) n_tima = wdata & tmask;
                    else if (fall) begin
                        if (m_tima[k] == tmask) begin n_tima = 0; n_left = rdl[k]; end
                        else n_tima = m_tima[k] + 1;
                    end
                end else if (m_left[k] > 0) begin
                    if (w_tima) begin n_tima = wdata & tmask; n_left = -1; end
                    else if (ce) n_left = m_left[k] - 1;
                end else begin
                    n_tima = w_tma ? (wdata & tmask) : m_tma[k];
                    n_left = -1;
                end
                m_div[k]  = w_div ? 0 : (ce ? ((m_div[k] + 1) & dmask) : m_div[k]);
                m_prev[k] = sel;
                m_tima[k] = n_tima;
                m_left[k] = n_left;
                if (w_tma) m_tma[k] = wdata & tmask;
                if (w_tac) m_tac[k] = wdata & 7;
            end
        end
        if (!nreset) started = 1;
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (started) begin
            check("rdata_a", rdata_a, exp_rdata(0, addr));
            check("irq_a",   irq_a,   m_left[0] == 0);
            check("taps_a",  taps_a,  m_div[0]);
            check("rdata_b", rdata_b, exp_rdata(1, addr));
            check("irq_b",   irq_b,   m_left[1] == 0);
            check("taps_b",  taps_b,  m_div[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cpu_wr = 1'b1; addr = a; wdata = d;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        addr = a;
        #1;
        v = rdata_a;
    endtask

    initial begin
        logic [7:0] v;
        int zeros, irqs;
        bit done, seen_zero;

        nreset = 1'b0; ce = 1'b0; cpu_wr = 1'b0; addr = 2'd0; wdata = 8'h00;
        repeat (2) tick();
        nreset = 1'b1;

        // Divider runs 256 ticks.
        ce = 1'b1;
        repeat (256) tick();
        ce = 1'b0;
        addr = 2'd0; #1;
        check("div_rd_256",  rdata_a, 8'h01);
        check("taps_256",    taps_a,  16'h0100);
        check("div_rd_256b", rdata_b, 8'h10);
        check("taps_256b",   taps_b,  12'h100);

        // Reset clears everything.
        nreset = 1'b0;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check("reset_rd", v, (a == 3) ? 8'hF8 : 8'h00);
        end
        check("reset_irq", irq_a, 1'b0);
        nreset = 1'b1;

        // TAC=5, TMA=AB, TIMA=FE: one increment then overflow and reload.
        wr(2'd0, 8'h00); wr(2'd3, 8'h05); wr(2'd2, 8'hAB); wr(2'd1, 8'hFE);
        ce = 1'b1;
        repeat (16) tick();
        ce = 1'b0;
        tick();
        rd(2'd1, v);
        check("tima_ff", v, 8'hFF);
        ce = 1'b1;
        zeros = 0; irqs = 0; done = 0; seen_zero = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (irq_a) irqs++;
            if (rdata_a == 8'h00) begin seen_zero = 1; zeros++; end
            else if (seen_zero) done = 1;
        end
        ce = 1'b0;
        check("ovf_done",  done,    1'b1);
        check("ovf_zeros", zeros,   5);
        check("ovf_irqs",  irqs,    1);
        check("reload_ab", rdata_a, 8'hAB);

        // TIMA write during the overflow wait cancels the reload.
        wr(2'd1, 8'hFF);
        ce = 1'b1; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (rdata_a == 8'h00) done = 1;
        end
        check("ovf2_seen", done, 1'b1);
        ce = 1'b0;
        wr(2'd1, 8'h42);
        irqs = 0;
        repeat (8) begin tick(); if (irq_a) irqs++; end
        rd(2'd1, v);
        check("ovf_cancel_tima", v, 8'h42);
        check("ovf_cancel_irq",  irqs, 0);

        // DIV write while the tap bit is high.
        wr(2'd0, 8'h00); wr(2'd1, 8'h10);
        ce = 1'b1; repeat (8) tick(); ce = 1'b0;
        wr(2'd0, 8'h00);
        tick();
        rd(2'd1, v);
        check("div_glitch_tima", v, 8'h11);
        check("div_glitch_taps", taps_a, 16'h0000);

        // TAC write that lowers sel.
        wr(2'd0, 8'h00);
        ce = 1'b1; repeat (8) tick(); ce = 1'b0;
        wr(2'd3, 8'h01);
        tick();
        rd(2'd1, v);
        check("tac_glitch_tima", v, 8'h12);
        wr(2'd3, 8'h05);

        // TMA write in the RELOAD clk feeds TIMA.
        wr(2'd2, 8'h10); wr(2'd0, 8'h00);
        ce = 1'b1; repeat (8) tick(); ce = 1'b0;
        wr(2'd1, 8'hFF);
        wr(2'd0, 8'h00);
        ce = 1'b1; irqs = 0; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (irq_a) begin
                irqs++; done = 1;
                ce = 1'b0;
                wr(2'd2, 8'h77);
            end
        end
        repeat (4) begin if (irq_a) irqs++; tick(); end
        rd(2'd1, v);
        check("rld_tma_tima", v, 8'h77);
        check("rld_tma_irqs", irqs, 1);
        rd(2'd2, v);
        check("rld_tma_tma", v, 8'h77);

        // Random traffic checked by the model only.
        for (int i = 0; i < 3000; i++) begin
            nreset = ($urandom_range(0, 199) != 0);
            ce     = ($urandom_range(0, 3) != 0);
            cpu_wr = ($urandom_range(0, 7) == 0);
            addr   = 2'($urandom);
            wdata  = 8'($urandom);
            tick();
        end
        nreset = 1'b1; ce = 1'b0; cpu_wr = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
